// File: rtl/alu8_pkg.sv
// rtl/alu8_pkg.sv - shared types and constants for the alu8 execute unit
// Contents: WIDTH, opcode_e (ADD..PASS = 0..15), TRUE_BYTE/FALSE_BYTE compare
// results, SIGNED_MAX/SIGNED_MIN boundary operands for INC/DEC overflow.
package alu8_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SLA  = 4'd8,
        OP_SRA  = 4'd9,
        OP_INC  = 4'd10,
        OP_DEC  = 4'd11,
        OP_EQ   = 4'd12,
        OP_LT   = 4'd13,
        OP_GT   = 4'd14,
        OP_PASS = 4'd15
    } opcode_e;

    localparam logic [WIDTH-1:0] TRUE_BYTE  = 8'hFF;
    localparam logic [WIDTH-1:0] FALSE_BYTE = 8'h00;
    localparam logic [WIDTH-1:0] SIGNED_MAX = 8'h7F;
    localparam logic [WIDTH-1:0] SIGNED_MIN = 8'h80;

endpackage

// File: rtl/alu8_if.sv
// rtl/alu8_if.sv - operand/result bus between the sequencer and alu8
// Signals: in_valid, a, b, opcode (sequencer -> alu);
//          out_valid, result, zero, carry, overflow, sign (alu -> sequencer).
// master: sequencer side; slave: alu8 side.
interface alu8_if;
    import alu8_pkg::*;

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             sign;

    modport master (
        output in_valid, a, b, opcode,
        input  out_valid, result, zero, carry, overflow, sign
    );

    modport slave (
        input  in_valid, a, b, opcode,
        output out_valid, result, zero, carry, overflow, sign
    );

endinterface

// File: rtl/alu8_comb.sv
// rtl/alu8_comb.sv - combinational result/carry/overflow for one alu8 op
// Ports: a, b (operands), op (opcode_e) -> result, carry, overflow.
// Optional: ALU8_SIGNED_CMP_EN makes LT/GT compare two's-complement values.
module alu8_comb
    import alu8_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_e          op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int MSB = WIDTH - 1;

    // One extra bit so carry/borrow falls out of the add/subtract directly.
    logic [WIDTH:0] ext;
    logic           lt;
    logic           gt;

    always_comb begin
        ext      = '0;
        lt       = 1'b0;
        gt       = 1'b0;
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        // Unary branches never read b, so an unknown b cannot reach the outputs.
        case (op)
            OP_ADD: begin
                ext      = {1'b0, a} + {1'b0, b};
                result   = ext[MSB:0];
                carry    = ext[WIDTH];
                overflow = (a[MSB] == b[MSB]) && (ext[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is set exactly when a < b.
                ext      = {1'b0, a} - {1'b0, b};
                result   = ext[MSB:0];
                carry    = ext[WIDTH];
                overflow = (a[MSB] != b[MSB]) && (ext[MSB] != a[MSB]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SLL: begin
                result = {a[MSB-1:0], 1'b0};
                carry  = a[MSB];
            end
            OP_SRL: begin
                result = {1'b0, a[MSB:1]};
                carry  = a[0];
            end
            OP_SLA: begin
                result   = {a[MSB-1:0], 1'b0};
                carry    = a[MSB];
                overflow = a[MSB] ^ a[MSB-1];
            end
            OP_SRA: begin
                result = {a[MSB], a[MSB:1]};
                carry  = a[0];
            end
            OP_INC: begin
                ext      = {1'b0, a} + (WIDTH+1)'(1);
                result   = ext[MSB:0];
                carry    = ext[WIDTH];
                overflow = (a == SIGNED_MAX);
            end
            OP_DEC: begin
                result   = a - WIDTH'(1);
                carry    = (a == '0);
                overflow = (a == SIGNED_MIN);
            end
            OP_EQ: result = (a == b) ? TRUE_BYTE : FALSE_BYTE;
            OP_LT: begin
`ifdef ALU8_SIGNED_CMP_EN
                lt = $signed(a) < $signed(b);
`else
                lt = a < b;
`endif
                result = lt ? TRUE_BYTE : FALSE_BYTE;
            end
            OP_GT: begin
`ifdef ALU8_SIGNED_CMP_EN
                gt = $signed(a) > $signed(b);
`else
                gt = a > b;
`endif
                result = gt ? TRUE_BYTE : FALSE_BYTE;
            end
            OP_PASS: result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu8.sv
// rtl/alu8.sv - 8-bit registered ALU, one cycle from in_valid to out_valid
// Ports: clk, rst_n (async assert, active-low), bus (alu8_if.slave):
//   in_valid/a/b/opcode in; out_valid/result/zero/carry/overflow/sign out.
// Optional: ALU8_SIGNED_CMP_EN (signed LT/GT, handled in alu8_comb).
module alu8
    import alu8_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    alu8_if.slave bus
);

    logic [WIDTH-1:0] comb_result;
    logic             comb_carry;
    logic             comb_overflow;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] result_d,    result_q;
    logic             zero_d,      zero_q;
    logic             carry_d,     carry_q;
    logic             overflow_d,  overflow_q;
    logic             sign_d,      sign_q;

    alu8_comb u_comb (
        .a        (bus.a),
        .b        (bus.b),
        .op       (opcode_e'(bus.opcode)),
        .result   (comb_result),
        .carry    (comb_carry),
        .overflow (comb_overflow)
    );

    // Without in_valid, result and flags keep the last issued op's values.
    always_comb begin
        out_valid_d = bus.in_valid;
        result_d    = result_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        sign_d      = sign_q;
        if (bus.in_valid) begin
            result_d   = comb_result;
            zero_d     = (comb_result == '0);
            carry_d    = comb_carry;
            overflow_d = comb_overflow;
            sign_d     = comb_result[WIDTH-1];
        end
    end

    // zero resets to 0 even though result resets to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            sign_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            sign_q      <= sign_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.sign      = sign_q;

endmodule

// File: tb/tb_alu8.sv
// tb/tb_alu8.sv - randomized and directed self-checking bench for alu8
module tb_alu8;
    import alu8_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu8_if bus ();

    alu8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // {out_valid, result, zero, carry, overflow, sign}
    logic [12:0] dut_vec;
    assign dut_vec = {bus.out_valid, bus.result, bus.zero, bus.carry, bus.overflow, bus.sign};

    function automatic int sx(input logic [7:0] x);
        int u;
        u = int'(x);
        return (u >= 128) ? u - 256 : u;
    endfunction

    function automatic bit out_of_range(input int s);
        return (s > 127) || (s < -128);
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] r, output bit c, output bit v);
        int ua, ub, sa, sb, t;
        ua = int'(x);
        sa = sx(x);
        ub = 0;
        sb = 0;
        t  = 0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            4'd0: begin ub = int'(y); sb = sx(y); t = ua + ub; c = (t > 255); v = out_of_range(sa + sb); end
            4'd1: begin ub = int'(y); sb = sx(y); t = ua - ub; c = (ua < ub); v = out_of_range(sa - sb); end
            4'd2: begin ub = int'(y); t = ua & ub; end
            4'd3: begin ub = int'(y); t = ua | ub; end
            4'd4: begin ub = int'(y); t = ua ^ ub; end
            4'd5: t = 255 - ua;
            4'd6: begin t = ua * 2; c = (ua >= 128); end
            4'd7: begin t = ua / 2; c = (ua % 2) == 1; end
            4'd8: begin t = ua * 2; c = (ua >= 128); v = out_of_range(sa * 2); end
            4'd9: begin t = (sa - (ua % 2)) / 2; c = (ua % 2) == 1; end
            4'd10: begin t = ua + 1; c = (t > 255); v = out_of_range(sa + 1); end
            4'd11: begin t = ua - 1; c = (ua == 0); v = out_of_range(sa - 1); end
            4'd12: begin ub = int'(y); t = (ua == ub) ? 255 : 0; end
`ifdef ALU8_SIGNED_CMP_EN
            4'd13: begin sb = sx(y); t = (sa < sb) ? 255 : 0; end
            4'd14: begin sb = sx(y); t = (sa > sb) ? 255 : 0; end
`else
            4'd13: begin ub = int'(y); t = (ua < ub) ? 255 : 0; end
            4'd14: begin ub = int'(y); t = (ua > ub) ? 255 : 0; end
`endif
            default: t = ua;
        endcase
        r = t[7:0];
    endfunction

    // Expected registered outputs, built from the model.
    logic [7:0] m_result = '0;
    bit         m_valid  = 1'b0;
    bit         m_zero   = 1'b0;
    bit         m_carry  = 1'b0;
    bit         m_ovf    = 1'b0;
    bit         m_sign   = 1'b0;
    logic [7:0] t_r;
    bit         t_c, t_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_result <= '0;
            m_zero   <= 1'b0;
            m_carry  <= 1'b0;
            m_ovf    <= 1'b0;
            m_sign   <= 1'b0;
        end else begin
            m_valid <= bus.in_valid;
            if (bus.in_valid) begin
                model(bus.opcode, bus.a, bus.b, t_r, t_c, t_v);
                m_result <= t_r;
                m_zero   <= (t_r == 8'h00);
                m_carry  <= t_c;
                m_ovf    <= t_v;
                m_sign   <= t_r[7];
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (dut_vec !== {m_valid, m_result, m_zero, m_carry, m_ovf, m_sign}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, dut_vec,
                         {m_valid, m_result, m_zero, m_carry, m_ovf, m_sign});
            end
        end
    end

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Issue one op, pin the model to the literal expectation, then check the DUT next cycle.
    task automatic dir(input string name, input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input bit ec, input bit ev);
        logic [7:0] mr;
        bit         mc, mv;
        logic [12:0] exp;
        exp = {1'b1, er, (er == 8'h00), ec, ev, er[7]};
        model(op, x, y, mr, mc, mv);
        check({name, "_model"}, {1'b1, mr, (mr == 8'h00), mc, mv, mr[7]}, exp);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = x;
        bus.b        = y;
        @(posedge clk);
        #1;
        check(name, dut_vec, exp);
    endtask

    logic [7:0] corner [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

    initial begin
        bus.in_valid = 1'b0;
        bus.opcode   = 4'd0;
        bus.a        = 8'h00;
        bus.b        = 8'h00;

        #2 rst_n = 1'b0;
        #1 check("reset_state", dut_vec, 13'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        dir("add_ff_01",  4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        dir("add_7f_01",  4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        dir("sub_00_01",  4'd1,  8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        dir("sub_80_01",  4'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        dir("dec_80",     4'd11, 8'h80, 8'hxx, 8'h7F, 1'b0, 1'b1);
        dir("dec_00",     4'd11, 8'h00, 8'hxx, 8'hFF, 1'b1, 1'b0);
        dir("inc_ff",     4'd10, 8'hFF, 8'hxx, 8'h00, 1'b1, 1'b0);
        dir("inc_7f",     4'd10, 8'h7F, 8'hxx, 8'h80, 1'b0, 1'b1);
        dir("sll_c0",     4'd6,  8'hC0, 8'hxx, 8'h80, 1'b1, 1'b0);
        dir("srl_01",     4'd7,  8'h01, 8'hxx, 8'h00, 1'b1, 1'b0);
        dir("sra_80",     4'd9,  8'h80, 8'hxx, 8'hC0, 1'b0, 1'b0);
        dir("sla_40",     4'd8,  8'h40, 8'hxx, 8'h80, 1'b0, 1'b1);
        dir("not_aa",     4'd5,  8'hAA, 8'hxx, 8'h55, 1'b0, 1'b0);
        dir("pass_aa",    4'd15, 8'hAA, 8'hxx, 8'hAA, 1'b0, 1'b0);
        dir("and_f0_0f",  4'd2,  8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0);
        dir("or_a0_05",   4'd3,  8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0);
        dir("xor_a5_5a",  4'd4,  8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0);
        dir("eq_55_55",   4'd12, 8'h55, 8'h55, 8'hFF, 1'b0, 1'b0);
        dir("lt_05_0a",   4'd13, 8'h05, 8'h0A, 8'hFF, 1'b0, 1'b0);
        dir("lt_05_05",   4'd13, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0);
        dir("gt_0a_05",   4'd14, 8'h0A, 8'h05, 8'hFF, 1'b0, 1'b0);
`ifdef ALU8_SIGNED_CMP_EN
        dir("lt_80_01",   4'd13, 8'h80, 8'h01, 8'hFF, 1'b0, 1'b0);
        dir("gt_80_01",   4'd14, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0);
`else
        dir("lt_80_01",   4'd13, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0);
        dir("gt_80_01",   4'd14, 8'h80, 8'h01, 8'hFF, 1'b0, 1'b0);
`endif

        // Hold: result/flags of PASS(3C) stay while in_valid is low.
        dir("pass_3c",    4'd15, 8'h3C, 8'hxx, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.opcode   = 4'(i);
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            @(posedge clk);
            #1;
            check("hold", dut_vec, {1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0});
        end

        // Asynchronous reset mid-cycle with an op in flight.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = 4'd0;
        bus.a        = 8'hFF;
        bus.b        = 8'h01;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset", dut_vec, 13'h0);
        @(posedge clk);
        #1 check("reset_held", dut_vec, 13'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic, biased toward boundary operands.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.opcode   = 4'($urandom_range(0, 15));
            bus.a        = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
            bus.b        = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
